// File: rtl/rx_byte_fifo.sv
// Receive-side byte FIFO (first-word-fall-through) between the UART receiver
// and the command core, with overrun flag, saturating drop counter and watermark.
module rx_byte_fifo #(
   parameter int unsigned DEPTH = 16
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic [7:0]                   write_data_i,
   input  logic                         write_valid_i,
   output logic [7:0]                   read_data_o,
   output logic                         read_valid_o,
   input  logic                         read_ready_i,
   output logic [$clog2(DEPTH):0]       count_o,
   output logic                         full_o,
   output logic [$clog2(DEPTH):0]       high_water_o,
   output logic                         overrun_o,
   output logic [7:0]                   drop_count_o,
   input  logic                         overrun_clear_i
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [AW:0]   count_next;
   logic [AW:0]   high_water;
   logic          overrun;
   logic [7:0]    drops;
   logic          push;
   logic          pop;
   logic          drop;

   assign read_valid_o = (count != '0);
   assign full_o       = (count == FULL_COUNT);
   assign read_data_o  = mem[rd_ptr];
   assign count_o      = count;
   assign high_water_o = high_water;
   assign overrun_o    = overrun;
   assign drop_count_o = drops;

   // A pop frees the slot in the same cycle, so a full queue still accepts a byte.
   assign pop  = read_valid_o & read_ready_i;
   assign push = write_valid_i & (~full_o | pop);
   assign drop = write_valid_i & full_o & ~pop;

   always_comb begin
      count_next = count;
      if (push && !pop)
         count_next = count + 1'b1;
      else if (!push && pop)
         count_next = count - 1'b1;
   end

   always_ff @(posedge clock) begin
      if (push)
         mem[wr_ptr] <= write_data_i;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count_next;
      end
   end

   // A drop in the same cycle as a clear takes priority and is counted as the first.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         high_water <= '0;
         overrun    <= 1'b0;
         drops      <= '0;
      end else begin
         if (overrun_clear_i)
            high_water <= count_next;
         else if (count_next > high_water)
            high_water <= count_next;

         if (drop)
            overrun <= 1'b1;
         else if (overrun_clear_i)
            overrun <= 1'b0;

         if (overrun_clear_i)
            drops <= drop ? 8'd1 : 8'd0;
         else if (drop && drops != 8'hFF)
            drops <= drops + 8'd1;
      end
   end

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Self-checking bench for rx_byte_fifo: queue-based reference model compared every
// cycle, plus directed literal checks at key points of each scenario.
module tb_rx_byte_fifo;

   logic       clock = 1'b0;
   logic       reset_n;
   logic [7:0] write_data_i = '0;
   logic       write_valid_i = 1'b0;
   logic [7:0] read_data_o;
   logic       read_valid_o;
   logic       read_ready_i = 1'b0;
   logic [4:0] count_o;
   logic       full_o;
   logic [4:0] high_water_o;
   logic       overrun_o;
   logic [7:0] drop_count_o;
   logic       overrun_clear_i = 1'b0;

   int errors = 0;
   int checks = 0;

   rx_byte_fifo #(.DEPTH(16)) dut (
      .clock(clock),
      .reset_n(reset_n),
      .write_data_i(write_data_i),
      .write_valid_i(write_valid_i),
      .read_data_o(read_data_o),
      .read_valid_o(read_valid_o),
      .read_ready_i(read_ready_i),
      .count_o(count_o),
      .full_o(full_o),
      .high_water_o(high_water_o),
      .overrun_o(overrun_o),
      .drop_count_o(drop_count_o),
      .overrun_clear_i(overrun_clear_i)
   );

   always #5 clock = ~clock;

   // Reference model
   byte unsigned q[$];
   int           m_hw = 0;
   bit           m_ovr = 0;
   int           m_drops = 0;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         q.delete();
         m_hw = 0;
         m_ovr = 0;
         m_drops = 0;
      end else begin
         bit do_pop, do_drop;
         do_pop  = (q.size() > 0) && read_ready_i;
         do_drop = write_valid_i && (q.size() == 16) && !do_pop;
         if (do_pop)
            void'(q.pop_front());
         if (write_valid_i && !do_drop)
            q.push_back(write_data_i);
         if (overrun_clear_i)
            m_hw = q.size();
         else if (q.size() > m_hw)
            m_hw = q.size();
         if (overrun_clear_i) begin
            m_ovr   = do_drop;
            m_drops = do_drop ? 1 : 0;
         end else if (do_drop) begin
            m_ovr = 1;
            if (m_drops < 255)
               m_drops++;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      chk("m_count", int'(count_o), q.size());
      chk("m_valid", int'(read_valid_o), (q.size() > 0) ? 1 : 0);
      chk("m_full", int'(full_o), (q.size() == 16) ? 1 : 0);
      chk("m_high_water", int'(high_water_o), m_hw);
      chk("m_overrun", int'(overrun_o), int'(m_ovr));
      chk("m_drops", int'(drop_count_o), m_drops);
      if (q.size() > 0)
         chk("m_data", int'(read_data_o), int'(q[0]));
   end

   // One clock cycle with the given inputs; returns 1 time unit after the edge.
   task automatic cyc(input bit wv, input byte unsigned d, input bit rdy, input bit clr);
      write_valid_i   = wv;
      write_data_i    = d;
      read_ready_i    = rdy;
      overrun_clear_i = clr;
      @(posedge clock);
      #1;
      write_valid_i   = 1'b0;
      read_ready_i    = 1'b0;
      overrun_clear_i = 1'b0;
   endtask

   initial begin
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      @(posedge clock);
      #1;
      chk("rst_count", int'(count_o), 0);
      chk("rst_valid", int'(read_valid_o), 0);
      chk("rst_full", int'(full_o), 0);
      chk("rst_hw", int'(high_water_o), 0);
      chk("rst_overrun", int'(overrun_o), 0);
      chk("rst_drops", int'(drop_count_o), 0);
      reset_n = 1'b1;

      // Basic push then ordered pop
      cyc(1, 8'h41, 0, 0);
      cyc(1, 8'h42, 0, 0);
      cyc(1, 8'h43, 0, 0);
      chk("t1_count", int'(count_o), 3);
      chk("t1_head", int'(read_data_o), 8'h41);
      chk("t1_hw", int'(high_water_o), 3);
      for (int i = 0; i < 3; i++) begin
         chk("t1_pop_data", int'(read_data_o), 8'h41 + i);
         cyc(0, 8'h00, 1, 0);
      end
      chk("t1_empty_valid", int'(read_valid_o), 0);
      chk("t1_empty_count", int'(count_o), 0);
      chk("t1_hw_hold", int'(high_water_o), 3);
      cyc(0, 8'h00, 1, 0);
      chk("t1_pop_empty", int'(count_o), 0);

      // Fill, overrun by two, drain
      for (int i = 0; i < 16; i++)
         cyc(1, byte'(i), 0, 0);
      chk("t2_full", int'(full_o), 1);
      cyc(1, 8'hAA, 0, 0);
      cyc(1, 8'hBB, 0, 0);
      chk("t2_overrun", int'(overrun_o), 1);
      chk("t2_drops", int'(drop_count_o), 2);
      chk("t2_count", int'(count_o), 16);
      for (int i = 0; i < 16; i++) begin
         chk("t2_drain", int'(read_data_o), i);
         cyc(0, 8'h00, 1, 0);
      end
      chk("t2_empty", int'(read_valid_o), 0);
      chk("t2_hw", int'(high_water_o), 16);

      // Push with simultaneous pop on a full queue
      for (int i = 0; i < 16; i++)
         cyc(1, byte'(i), 0, 0);
      cyc(0, 8'h00, 0, 1);
      chk("t3_clr_overrun", int'(overrun_o), 0);
      chk("t3_clr_hw", int'(high_water_o), 16);
      cyc(1, 8'h55, 1, 0);
      chk("t3_count", int'(count_o), 16);
      chk("t3_overrun", int'(overrun_o), 0);
      chk("t3_drops", int'(drop_count_o), 0);
      for (int i = 1; i < 16; i++) begin
         chk("t3_drain", int'(read_data_o), i);
         cyc(0, 8'h00, 1, 0);
      end
      chk("t3_last", int'(read_data_o), 8'h55);
      cyc(0, 8'h00, 1, 0);
      chk("t3_empty", int'(count_o), 0);

      // Continuous stream at occupancy one, wrapping the pointers
      cyc(0, 8'h00, 0, 1);
      chk("t4_hw_clr", int'(high_water_o), 0);
      cyc(1, 8'd3, 0, 0);
      for (int i = 1; i < 40; i++) begin
         chk("t4_stream", int'(read_data_o), (((i - 1) * 7) + 3) & 8'hFF);
         cyc(1, byte'(i * 7 + 3), 1, 0);
      end
      chk("t4_last", int'(read_data_o), ((39 * 7) + 3) & 8'hFF);
      cyc(0, 8'h00, 1, 0);
      chk("t4_empty", int'(count_o), 0);
      chk("t4_hw", int'(high_water_o), 1);

      // Drop counter saturation and clear interaction
      for (int i = 0; i < 16; i++)
         cyc(1, byte'(8'hC0 + i), 0, 0);
      for (int i = 0; i < 300; i++)
         cyc(1, 8'hEE, 0, 0);
      chk("t5_sat", int'(drop_count_o), 255);
      chk("t5_overrun", int'(overrun_o), 1);
      cyc(0, 8'h00, 0, 1);
      chk("t5_clr_overrun", int'(overrun_o), 0);
      chk("t5_clr_drops", int'(drop_count_o), 0);
      chk("t5_clr_hw", int'(high_water_o), 16);
      cyc(1, 8'hEE, 0, 1);
      chk("t5_coinc_overrun", int'(overrun_o), 1);
      chk("t5_coinc_drops", int'(drop_count_o), 1);
      chk("t5_head_kept", int'(read_data_o), 8'hC0);

      // Asynchronous reset with five bytes queued
      for (int i = 0; i < 11; i++)
         cyc(0, 8'h00, 1, 0);
      chk("t6_queued", int'(count_o), 5);
      #3 reset_n = 1'b0;
      #1;
      chk("t6_async_count", int'(count_o), 0);
      chk("t6_async_valid", int'(read_valid_o), 0);
      chk("t6_async_overrun", int'(overrun_o), 0);
      @(posedge clock);
      #1 reset_n = 1'b1;
      cyc(1, 8'h99, 0, 0);
      chk("t6_post_valid", int'(read_valid_o), 1);
      chk("t6_post_data", int'(read_data_o), 8'h99);
      chk("t6_post_count", int'(count_o), 1);
      cyc(0, 8'h00, 1, 0);
      cyc(0, 8'h00, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rx_byte_fifo.md
# rx_byte_fifo

Receive-side byte FIFO between the UART receiver and the command core in the lowspeed design. It absorbs bursts of incoming bytes while the core is busy, so the core can stall without losing data. It also reports overruns: a sticky flag, a saturating drop counter and a peak-occupancy watermark, all fed to the LED error word.

## Interface

- DEPTH, 16, number of byte slots; power of two, 2..256
- AW, log2(DEPTH), pointer width; derived, not overridden
- clock  input  1  system clock (12 MHz), all state on rising edge
- reset_n  input  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low
- write_data_i  input  8  received byte
- write_valid_i  input  1  one-cycle strobe, byte present on write_data_i
- read_data_o  output  8  head-of-queue byte (first-word-fall-through)
- read_valid_o  output  1  queue non-empty, read_data_o meaningful
- read_ready_i  input  1  consumer accepts head byte this cycle
- count_o  output  AW+1  current occupancy, 0..DEPTH
- full_o  output  1  count_o == DEPTH
- high_water_o  output  AW+1  peak count_o since reset/clear
- overrun_o  output  1  sticky, at least one byte dropped
- drop_count_o  output  8  bytes dropped, saturates at 255
- overrun_clear_i  input  1  clears overrun_o, drop_count_o, high_water_o

## Operation

- Storage: DEPTH x 8 register array; wr_ptr, rd_ptr AW bits, wrap modulo DEPTH; separate count register AW+1 bits.
- push = write_valid_i & (~full_o | pop); pop = read_valid_o & read_ready_i.
- Push writes mem[wr_ptr], wr_ptr+1. Pop advances rd_ptr+1. count: +1 push only, -1 pop only, unchanged both/neither.
- Full with simultaneous push and pop: byte accepted, count stays DEPTH, no overrun.
- Drop = write_valid_i & full_o & ~pop: byte discarded, pointers unchanged, overrun_o<=1, drop_count_o increments unless 255.
- read_data_o = mem[rd_ptr] combinationally; undefined (don't-care) when read_valid_o=0.
- read_ready_i when empty: no effect.
- high_water_o <= max(high_water_o, next count) every cycle.
- overrun_clear_i: overrun_o<=0, drop_count_o<=0, high_water_o<=next count. Same cycle as a drop: drop wins (overrun_o=1, drop_count_o=1). Queue contents unaffected.
- No state machine beyond pointers; no flow control upstream (UART has none).

## Timing

- Reset (reset_n low, async): wr_ptr=rd_ptr=0, count_o=0, read_valid_o=0, full_o=0, high_water_o=0, overrun_o=0, drop_count_o=0. Memory contents not reset.
- Reset release synchronised externally; first push accepted on first rising edge with reset_n high.
- Write-to-read latency: push at edge N -> read_valid_o=1 and read_data_o valid after edge N (one cycle).
- Pop at edge N -> next byte (if any) on read_data_o after edge N; back-to-back pops every cycle sustain full throughput.
- full_o, count_o, read_valid_o all registered/derived from registered count; no combinational path from write_valid_i or read_ready_i to any output.
- Reset asserted mid-burst: all queued bytes lost, outputs return to reset values immediately.

## Test plan

- Reset, then push 0x41,0x42,0x43 on consecutive cycles with read_ready_i=0 -> count_o=3, read_data_o=0x41, high_water_o=3; then pop 3 consecutive cycles -> 0x41,0x42,0x43 in order, read_valid_o=0, count_o=0, high_water_o stays 3.
- Fill DEPTH=16 with 0x00..0x0F, push 0xAA, 0xBB without pop -> full_o=1, overrun_o=1, drop_count_o=2; drain returns 0x00..0x0F exactly, 0xAA/0xBB absent.
- Full queue, push 0x55 with simultaneous pop -> accepted, count_o stays 16, overrun_o=0; drained last byte is 0x55.
- Push/pop 40 bytes in a continuous stream with occupancy near 1 -> pointer wrap correct, all 40 bytes in order, high_water_o<=2.
- 300 pushes while full without pop -> drop_count_o saturates at 255; overrun_clear_i pulse -> overrun_o=0, drop_count_o=0, high_water_o=16; clear coincident with a drop -> overrun_o=1, drop_count_o=1.
- Assert reset_n low asynchronously with 5 bytes queued -> count_o=0, read_valid_o=0 without waiting for a clock edge; post-release push 0x99 -> read_data_o=0x99 next cycle.
